branch_predictor_2bit: RTL and testbench

//  Per-branch 2-bit saturating-counter branch history table (BHT) for the 5-stage RV32 core.
//  - IF stage: predicts taken / not-taken for conditional branches (opcode 1100011).
//  - ID stage: carries the prediction alongside the IF/ID register and checks it against the resolved outcome.
//  - Drives 'correct' into the hazard unit, which flushes on correct==0.
//  - Keeps branch and mispredict statistics counters.

---
 rtl/branch_predictor_2bit.sv | 116 +++++++++++
 tb/tb_branch_predictor_2bit.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor_2bit.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predictor_2bit
//  Description : Per-branch 2-bit saturating-counter branch history table.
//                Predicts in IF, tracks the IF/ID entry, checks the outcome
//                in ID, and updates counters and branch statistics.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor_2bit #(
    parameter int         IDX_W      = 5,
    parameter logic [1:0] INIT_STATE = 2'b01,
    parameter int         CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      if_pc,
    input  logic             if_is_branch,
    input  logic             if_id_stall,
    input  logic             if_id_flush,
    input  logic             id_resolve,
    input  logic             id_taken,
    output logic             predict_taken,
    output logic             correct,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] miss_count
);

    localparam int c_ENTRIES = 1 << IDX_W;

    logic [1:0]       r_bht [c_ENTRIES];
    logic             r_pend_valid;
    logic             r_pend_pred;
    logic [IDX_W-1:0] r_pend_idx;
    logic             r_pend_done;
    logic [CNT_W-1:0] r_br_count;
    logic [CNT_W-1:0] r_miss_count;

    logic [IDX_W-1:0] w_idx;
    logic             w_predict;
    logic             w_upd;
    logic             w_miss;
    logic [1:0]       w_cur;
    logic [1:0]       w_next;

    // PC bits outside the index field are deliberately ignored (aliasing, no tags)
    logic             w_unused_pc_bits;
    assign w_unused_pc_bits = ^{if_pc[31:IDX_W+2], if_pc[1:0]};

    // IF-stage lookup: read returns the stored value, no bypass of a same-edge write
    assign w_idx     = if_pc[IDX_W+1:2];
    assign w_predict = if_is_branch & r_bht[w_idx][1];

    // One update per pending branch; correct is independent of the stall input
    assign w_upd  = r_pend_valid & ~r_pend_done & id_resolve;
    assign w_miss = w_upd & (id_taken != r_pend_pred);

    // Saturating 2-bit counter step for the pending entry
    assign w_cur  = r_bht[r_pend_idx];
    always_comb begin
        w_next = w_cur;
        if (id_taken) begin
            if (w_cur != 2'b11) w_next = w_cur + 2'd1;
        end else begin
            if (w_cur != 2'b00) w_next = w_cur - 2'd1;
        end
    end

    // History table: reset to INIT_STATE, write the resolved entry on update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < c_ENTRIES; i++) begin
                r_bht[i] <= INIT_STATE;
            end
        end else if (w_upd) begin
            r_bht[r_pend_idx] <= w_next;
        end
    end

    // Pending register mirrors the IF/ID entry; stall wins over flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_valid <= 1'b0;
            r_pend_pred  <= 1'b0;
            r_pend_idx   <= '0;
            r_pend_done  <= 1'b0;
        end else if (if_id_stall) begin
            if (w_upd) r_pend_done <= 1'b1;
        end else if (if_id_flush) begin
            r_pend_valid <= 1'b0;
            r_pend_done  <= 1'b0;
        end else begin
            r_pend_valid <= if_is_branch;
            r_pend_pred  <= w_predict;
            r_pend_idx   <= w_idx;
            r_pend_done  <= 1'b0;
        end
    end

    // Statistics counters saturate at all-ones instead of wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_br_count   <= '0;
            r_miss_count <= '0;
        end else if (w_upd) begin
            if (~&r_br_count)             r_br_count   <= r_br_count + 1'b1;
            if (w_miss && ~&r_miss_count) r_miss_count <= r_miss_count + 1'b1;
        end
    end

    assign predict_taken = w_predict;
    assign correct       = ~w_miss;
    assign br_count      = r_br_count;
    assign miss_count    = r_miss_count;

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor_2bit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_predictor_2bit
//  Description : Directed self-checking bench for branch_predictor_2bit.
//                Inputs change on the falling edge; outputs are checked 1 ns
//                later, well away from the rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predictor_2bit;

    logic        clk;
    logic        rst_n;
    logic [31:0] if_pc;
    logic        if_is_branch;
    logic        if_id_stall;
    logic        if_id_flush;
    logic        id_resolve;
    logic        id_taken;
    logic        predict_taken;
    logic        correct;
    logic [31:0] br_count;
    logic [31:0] miss_count;

    int checks;
    int errors;

    branch_predictor_2bit #(
        .IDX_W      (5),
        .INIT_STATE (2'b01),
        .CNT_W      (32)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .if_pc         (if_pc),
        .if_is_branch  (if_is_branch),
        .if_id_stall   (if_id_stall),
        .if_id_flush   (if_id_flush),
        .id_resolve    (id_resolve),
        .id_taken      (id_taken),
        .predict_taken (predict_taken),
        .correct       (correct),
        .br_count      (br_count),
        .miss_count    (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of inputs on the falling edge, then settle
    task automatic drive(input logic [31:0] pc, input logic br, input logic stall,
                         input logic flush, input logic res, input logic tkn);
        @(negedge clk);
        if_pc        = pc;
        if_is_branch = br;
        if_id_stall  = stall;
        if_id_flush  = flush;
        id_resolve   = res;
        id_taken     = tkn;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        if_pc = 32'h0; if_is_branch = 1'b0; if_id_stall = 1'b0;
        if_id_flush = 1'b0; id_resolve = 1'b0; id_taken = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        if_pc = 32'h40; if_is_branch = 1'b1; if_id_stall = 1'b0;
        if_id_flush = 1'b0; id_resolve = 1'b1; id_taken = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (predict_taken !== 1'b0) begin errors++; $display("FAIL reset_pred got %b exp 0", predict_taken); end
        checks++;
        if (correct !== 1'b1) begin errors++; $display("FAIL reset_correct got %b exp 1", correct); end
        checks++;
        if (br_count !== 32'd0 || miss_count !== 32'd0) begin
            errors++; $display("FAIL reset_counts got %0d/%0d exp 0/0", br_count, miss_count);
        end
        rst_n = 1'b1;
        id_resolve = 1'b0;
    endtask

    // Branch 0x40 resolved taken twice: 01 -> 10 -> 11
    task automatic test_train();
        do_reset();
        drive(32'h40, 1, 0, 0, 0, 0);
        checks++;
        if (predict_taken !== 1'b0) begin errors++; $display("FAIL train_pred0 got %b exp 0", predict_taken); end
        drive(32'h100, 0, 0, 0, 1, 1);
        checks++;
        if (correct !== 1'b0) begin errors++; $display("FAIL train_miss1 got %b exp 0", correct); end
        drive(32'h40, 1, 0, 0, 0, 0);
        checks++;
        if (predict_taken !== 1'b1) begin errors++; $display("FAIL train_pred1 got %b exp 1", predict_taken); end
        checks++;
        if (dut.r_bht[16] !== 2'b10) begin errors++; $display("FAIL train_bht1 got %b exp 10", dut.r_bht[16]); end
        drive(32'h100, 0, 0, 0, 1, 1);
        checks++;
        if (correct !== 1'b1) begin errors++; $display("FAIL train_hit2 got %b exp 1", correct); end
        drive(32'h40, 1, 0, 0, 0, 0);
        checks++;
        if (predict_taken !== 1'b1 || dut.r_bht[16] !== 2'b11) begin
            errors++; $display("FAIL train_sat got pred %b bht %b exp 1/11", predict_taken, dut.r_bht[16]);
        end
        checks++;
        if (br_count !== 32'd2 || miss_count !== 32'd1) begin
            errors++; $display("FAIL train_counts got %0d/%0d exp 2/1", br_count, miss_count);
        end
    endtask

    // Mispredict flagged combinationally; miss counter moves at the next edge
    task automatic test_mispredict();
        do_reset();
        drive(32'h44, 1, 0, 0, 0, 0);
        drive(32'h0, 0, 0, 0, 1, 1);
        checks++;
        if (correct !== 1'b0 || miss_count !== 32'd0) begin
            errors++; $display("FAIL mis_same_cycle got correct %b miss %0d exp 0/0", correct, miss_count);
        end
        drive(32'h0, 0, 0, 0, 0, 0);
        checks++;
        if (miss_count !== 32'd1 || br_count !== 32'd1) begin
            errors++; $display("FAIL mis_counts got %0d/%0d exp 1/1", br_count, miss_count);
        end
    endtask

    // Stall held for 3 cycles with resolve high: single update, pend held
    task automatic test_stall();
        do_reset();
        drive(32'h48, 1, 0, 0, 0, 0);
        drive(32'h40, 1, 1, 0, 1, 1);
        checks++;
        if (correct !== 1'b0) begin errors++; $display("FAIL stall_first got %b exp 0", correct); end
        drive(32'h40, 1, 1, 0, 1, 1);
        checks++;
        if (correct !== 1'b1) begin errors++; $display("FAIL stall_second got %b exp 1", correct); end
        drive(32'h40, 1, 1, 0, 1, 1);
        checks++;
        if (correct !== 1'b1) begin errors++; $display("FAIL stall_third got %b exp 1", correct); end
        drive(32'h0, 0, 0, 0, 0, 0);
        checks++;
        if (br_count !== 32'd1 || miss_count !== 32'd1 || dut.r_bht[18] !== 2'b10) begin
            errors++; $display("FAIL stall_once got br %0d miss %0d bht %b exp 1/1/10",
                               br_count, miss_count, dut.r_bht[18]);
        end
        checks++;
        if (dut.r_pend_valid !== 1'b1 || dut.r_pend_idx !== 5'd18) begin
            errors++; $display("FAIL stall_hold got valid %b idx %0d exp 1/18", dut.r_pend_valid, dut.r_pend_idx);
        end
    endtask

    // Flush kills the pending branch; stall has priority over flush
    task automatic test_flush();
        do_reset();
        drive(32'h4C, 1, 0, 0, 0, 0);
        drive(32'h0, 0, 0, 1, 0, 0);
        drive(32'h0, 0, 0, 0, 1, 1);
        checks++;
        if (correct !== 1'b1) begin errors++; $display("FAIL flush_correct got %b exp 1", correct); end
        drive(32'h4C, 1, 0, 0, 0, 0);
        checks++;
        if (br_count !== 32'd0 || dut.r_bht[19] !== 2'b01) begin
            errors++; $display("FAIL flush_noupd got br %0d bht %b exp 0/01", br_count, dut.r_bht[19]);
        end
        drive(32'h0, 0, 1, 1, 0, 0);
        drive(32'h0, 0, 0, 0, 1, 1);
        checks++;
        if (correct !== 1'b0) begin errors++; $display("FAIL stall_over_flush got %b exp 0", correct); end
    endtask

    // Not-taken training saturates at 00
    task automatic test_not_taken();
        do_reset();
        drive(32'h50, 1, 0, 0, 0, 0);
        drive(32'h50, 1, 0, 0, 1, 0);
        checks++;
        if (correct !== 1'b1) begin errors++; $display("FAIL nt_first got %b exp 1", correct); end
        drive(32'h0, 0, 0, 0, 1, 0);
        checks++;
        if (correct !== 1'b1) begin errors++; $display("FAIL nt_second got %b exp 1", correct); end
        drive(32'h0, 0, 0, 0, 0, 0);
        checks++;
        if (dut.r_bht[20] !== 2'b00 || br_count !== 32'd2 || miss_count !== 32'd0) begin
            errors++; $display("FAIL nt_sat got bht %b br %0d miss %0d exp 00/2/0",
                               dut.r_bht[20], br_count, miss_count);
        end
    endtask

    // 0x40 and 0xC0 alias to entry 16; back-to-back resolve+fetch, no bypass
    task automatic test_back_to_back();
        do_reset();
        drive(32'h40, 1, 0, 0, 0, 0);
        drive(32'hC0, 1, 0, 0, 1, 1);
        checks++;
        if (predict_taken !== 1'b0 || correct !== 1'b0) begin
            errors++; $display("FAIL b2b_nobypass got pred %b correct %b exp 0/0", predict_taken, correct);
        end
        drive(32'h40, 1, 0, 0, 1, 1);
        checks++;
        if (predict_taken !== 1'b1 || correct !== 1'b0) begin
            errors++; $display("FAIL b2b_alias1 got pred %b correct %b exp 1/0", predict_taken, correct);
        end
        drive(32'hC0, 1, 0, 0, 1, 1);
        checks++;
        if (predict_taken !== 1'b1 || correct !== 1'b1) begin
            errors++; $display("FAIL b2b_alias2 got pred %b correct %b exp 1/1", predict_taken, correct);
        end
        drive(32'h40, 1, 0, 0, 1, 1);
        drive(32'h0, 0, 0, 0, 1, 0);
        checks++;
        if (dut.r_bht[16] !== 2'b11 || correct !== 1'b0) begin
            errors++; $display("FAIL b2b_sat got bht %b correct %b exp 11/0", dut.r_bht[16], correct);
        end
        drive(32'hC0, 1, 0, 0, 0, 0);
        checks++;
        if (dut.r_bht[16] !== 2'b10 || predict_taken !== 1'b1) begin
            errors++; $display("FAIL b2b_dec got bht %b pred %b exp 10/1", dut.r_bht[16], predict_taken);
        end
        checks++;
        if (br_count !== 32'd5 || miss_count !== 32'd3) begin
            errors++; $display("FAIL b2b_counts got %0d/%0d exp 5/3", br_count, miss_count);
        end
        drive(32'h40, 0, 0, 0, 0, 0);
        checks++;
        if (predict_taken !== 1'b0) begin errors++; $display("FAIL nonbranch_pred got %b exp 0", predict_taken); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        if_pc = 32'h0; if_is_branch = 1'b0; if_id_stall = 1'b0;
        if_id_flush = 1'b0; id_resolve = 1'b0; id_taken = 1'b0;
        test_reset();
        test_train();
        test_mispredict();
        test_stall();
        test_flush();
        test_not_taken();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
